score_keeper: RTL and testbench



---
 rtl/score_keeper.sv | 138 +++++++++++++
 tb/tb_score_keeper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: level-weighted scoring for Tetris line-clear events.
// Keeps saturating game score, total lines, level and session high score.
`default_nettype none

module score_keeper #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9,
  parameter int SCORE_MAX       = 999,
  parameter int PTS_1           = 1,
  parameter int PTS_2           = 3,
  parameter int PTS_3           = 5,
  parameter int PTS_4           = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_valid,
  input  logic [2:0] clr_lines,
  output logic       clr_ready,
  input  logic       new_game,
  input  logic       game_over,
  output logic [9:0] game_score,
  output logic [3:0] level,
  output logic [9:0] lines_total,
  output logic [9:0] high_score,
  output logic       score_pulse
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCUM  = 2'd1;
  localparam logic [1:0]  ST_UPDATE = 2'd2;

  localparam logic [10:0] SCORE_CAP = 11'(SCORE_MAX);
  localparam logic [10:0] LINES_CAP = 11'd1023;
  localparam logic [6:0]  LPL       = 7'(LINES_PER_LEVEL);
  localparam logic [3:0]  LVL_CAP   = 4'(MAX_LEVEL);

  logic [1:0]  state;
  logic [9:0]  base;
  logic [4:0]  reps;
  logic [2:0]  lines_q;
  logic [5:0]  lines_in_level;
  logic        game_over_q;

  logic [9:0]  base_sel;
  logic        legal;
  logic        accept;
  logic [10:0] score_sum;
  logic [10:0] total_sum;
  logic [6:0]  lil_sum;
  logic        hs_eval;

  always_comb begin
    base_sel = '0;
    legal    = 1'b1;
    case (clr_lines)
      3'd1:    base_sel = 10'(PTS_1);
      3'd2:    base_sel = 10'(PTS_2);
      3'd3:    base_sel = 10'(PTS_3);
      3'd4:    base_sel = 10'(PTS_4);
      default: legal    = 1'b0;
    endcase
  end

  assign clr_ready = (state == ST_IDLE) && !game_over;
  // new_game wins over a simultaneous event, whatever clr_ready says
  assign accept    = clr_valid && clr_ready && !new_game;

  assign score_sum = {1'b0, game_score} + {1'b0, base};
  assign total_sum = {1'b0, lines_total} + {8'd0, lines_q};
  assign lil_sum   = {1'b0, lines_in_level} + {4'd0, lines_q};

  // Re-evaluating during UPDATE catches the final score of an event that was in flight at game over
  assign hs_eval = (game_over && !game_over_q) || (state == ST_UPDATE && game_over);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      base           <= '0;
      reps           <= '0;
      lines_q        <= '0;
      lines_in_level <= '0;
      game_over_q    <= 1'b0;
      game_score     <= '0;
      level          <= '0;
      lines_total    <= '0;
      high_score     <= '0;
      score_pulse    <= 1'b0;
    end else begin
      game_over_q <= game_over;
      score_pulse <= 1'b0;

      if (hs_eval && (game_score > high_score)) begin
        high_score <= game_score;
      end

      if (new_game) begin
        state          <= ST_IDLE;
        game_score     <= '0;
        level          <= '0;
        lines_total    <= '0;
        lines_in_level <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept && legal) begin
              base    <= base_sel;
              reps    <= {1'b0, level} + 5'd1;
              lines_q <= clr_lines;
              state   <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            game_score <= (score_sum > SCORE_CAP) ? SCORE_CAP[9:0] : score_sum[9:0];
            reps       <= reps - 5'd1;
            if (reps == 5'd1) begin
              state       <= ST_UPDATE;
              score_pulse <= 1'b1;
            end
          end
          ST_UPDATE: begin
            lines_total <= (total_sum > LINES_CAP) ? LINES_CAP[9:0] : total_sum[9:0];
            if (lil_sum >= LPL) begin
              lines_in_level <= 6'(lil_sum - LPL);
              level          <= (level >= LVL_CAP) ? LVL_CAP : level + 4'd1;
            end else begin
              lines_in_level <= lil_sum[5:0];
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized self-checking bench for score_keeper against an
// arithmetic reference model (score = sum of base*(level+1), level = lines/LPL).
`default_nettype none

module tb_score_keeper;

  localparam int LPL  = 10;
  localparam int MAXL = 9;
  localparam int SMAX = 999;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr_valid;
  logic [2:0] clr_lines;
  logic       clr_ready;
  logic       new_game;
  logic       game_over;
  logic [9:0] game_score;
  logic [3:0] level;
  logic [9:0] lines_total;
  logic [9:0] high_score;
  logic       score_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_score = 0;
  int m_lines = 0;   // unsaturated lines this game
  int m_high  = 0;

  score_keeper #(
    .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL), .SCORE_MAX(SMAX),
    .PTS_1(1), .PTS_2(3), .PTS_3(5), .PTS_4(8)
  ) dut (
    .clk(clk), .rstn(rstn), .clr_valid(clr_valid), .clr_lines(clr_lines),
    .clr_ready(clr_ready), .new_game(new_game), .game_over(game_over),
    .game_score(game_score), .level(level), .lines_total(lines_total),
    .high_score(high_score), .score_pulse(score_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pts(input int n);
    case (n)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int m_level();
    return (m_lines / LPL > MAXL) ? MAXL : m_lines / LPL;
  endfunction

  function automatic int m_total();
    return (m_lines > 1023) ? 1023 : m_lines;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_score"}, 32'(game_score), 32'(m_score));
    check({tag, "_lines"}, 32'(lines_total), 32'(m_total()));
    check({tag, "_level"}, 32'(level), 32'(m_level()));
    check({tag, "_high"}, 32'(high_score), 32'(m_high));
  endtask

  // Called on a negedge with game_over low. go_at > 0 raises game_over at that ACCUM negedge.
  task automatic do_event(input int n, input int go_at);
    int lv, exp_score, k, pk;
    lv = m_level();
    clr_valid = 1'b1;
    clr_lines = 3'(n);
    #1 check("ready_before", 32'(clr_ready), 32'd1);
    @(posedge clk);
    #1 clr_valid = 1'b0;
    if (n < 1 || n > 4) begin
      @(negedge clk);
      check("illegal_ready", 32'(clr_ready), 32'd1);
      check("illegal_pulse", 32'(score_pulse), 32'd0);
      check_state("illegal");
      return;
    end
    exp_score = m_score + pts(n) * (lv + 1);
    if (exp_score > SMAX) exp_score = SMAX;
    k  = 0;
    pk = 0;
    while (pk == 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == go_at) game_over = 1'b1;
      if (score_pulse) begin
        pk = k;
        check("score_at_update", 32'(game_score), 32'(exp_score));
      end else begin
        check("ready_busy", 32'(clr_ready), 32'd0);
      end
    end
    check("pulse_latency", 32'(pk), 32'(lv + 2));
    m_score = exp_score;
    m_lines += n;
    if (go_at > 0 && m_score > m_high) m_high = m_score;
    @(negedge clk);
    check("pulse_single", 32'(score_pulse), 32'd0);
    check("ready_after", 32'(clr_ready), 32'(!game_over));
    check_state("event");
    if (game_over) begin
      game_over = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    m_score = 0;
    m_lines = 0;
    @(negedge clk);
    check("ng_ready", 32'(clr_ready), 32'd1);
    check_state("new_game");
  endtask

  // Raise game_over while idle, hold a 3-line request that must be refused
  task automatic do_game_over();
    game_over = 1'b1;
    clr_valid = 1'b1;
    clr_lines = 3'd3;
    #1 check("go_ready", 32'(clr_ready), 32'd0);
    if (m_score > m_high) m_high = m_score;
    repeat (2) begin
      @(negedge clk);
      check("go_pulse", 32'(score_pulse), 32'd0);
      check_state("game_over");
    end
    clr_valid = 1'b0;
    game_over = 1'b0;
    @(negedge clk);
    check("go_release_ready", 32'(clr_ready), 32'd1);
  endtask

  // Abort an event with new_game one cycle into ACCUM
  task automatic do_abort(input int n);
    clr_valid = 1'b1;
    clr_lines = 3'(n);
    @(posedge clk);
    #1 clr_valid = 1'b0;
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    m_score = 0;
    m_lines = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_pulse", 32'(score_pulse), 32'd0);
      check("abort_ready", 32'(clr_ready), 32'd1);
      check_state("abort");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rstn      = 1'b0;
    clr_valid = 1'b0;
    clr_lines = 3'd0;
    new_game  = 1'b0;
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(clr_ready), 32'd1);
    check("reset_pulse", 32'(score_pulse), 32'd0);
    check_state("reset");
    rstn = 1'b1;

    // idle after reset
    repeat (5) begin
      @(negedge clk);
      check("idle_pulse", 32'(score_pulse), 32'd0);
    end
    check_state("idle");

    // single 4-line clear at level 0, then five 2-line clears and one at level 1
    do_event(4, 0);
    do_new_game();
    repeat (5) do_event(2, 0);
    check("five_events_score", 32'(game_score), 32'd15);
    check("five_events_level", 32'(level), 32'd1);
    do_event(2, 0);
    check("level1_score", 32'(game_score), 32'd21);

    // game over at 21, refused request, then an illegal 0-line event
    do_game_over();
    check("high_21", 32'(high_score), 32'd21);
    do_event(0, 0);

    // abort in flight at level 1
    do_event(4, 0);
    do_abort(3);

    // game over raised while an event is accumulating
    repeat (12) do_event(4, 0);
    do_event(3, 2);

    // randomized mix
    do_new_game();
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       do_new_game();
      else if (r < 9)  do_game_over();
      else if (r < 13) do_event($urandom_range(1, 4), 1);
      else             do_event($urandom_range(0, 7), 0);
    end

    // push score, level and lines_total into saturation
    do_new_game();
    for (int i = 0; i < 265; i++) do_event(4, 0);
    check("sat_score", 32'(game_score), 32'(SMAX));
    check("sat_level", 32'(level), 32'(MAXL));
    check("sat_lines", 32'(lines_total), 32'd1023);
    do_event(1, 0);
    do_game_over();
    check("sat_high", 32'(high_score), 32'(SMAX));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
